// File: rtl/sin24b_pkg.sv
// Shared widths, datapath type and CORDIC constants for the sin24b sine generator.
package sin24b_pkg;

  localparam int unsigned IN_W  = 24;
  localparam int unsigned OUT_W = 25;
  localparam int unsigned GUARD = 3;
  localparam int unsigned DP_W  = IN_W + GUARD + 2;

  // Signed x/y/z datapath word: two integer bits above the Q.(24+GUARD) fraction.
  typedef logic signed [DP_W-1:0] dp_t;

  // round(0.6072529350 * 2^(24+GUARD)): start vector length that cancels the CORDIC gain.
  localparam dp_t K_INIT = 29'd81504109;

  // Half an output LSB in datapath units, used for round-half-up.
  localparam dp_t RND_HALF = DP_W'(1 << (GUARD - 1));

  // round(atan(2^-k) / (pi/2) * 2^(24+GUARD)); angles are kept in quarter-turn units.
  function automatic dp_t atan_lut(input int unsigned k);
    dp_t v;
    v = '0;
    case (k)
      0:  v = 29'd67108864;
      1:  v = 29'd39616676;
      2:  v = 29'd20932363;
      3:  v = 29'd10625595;
      4:  v = 29'd5333416;
      5:  v = 29'd2669308;
      6:  v = 29'd1334980;
      7:  v = 29'd667531;
      8:  v = 29'd333770;
      9:  v = 29'd166886;
      10: v = 29'd83443;
      11: v = 29'd41722;
      12: v = 29'd20861;
      13: v = 29'd10430;
      14: v = 29'd5215;
      15: v = 29'd2608;
      16: v = 29'd1304;
      17: v = 29'd652;
      18: v = 29'd326;
      19: v = 29'd163;
      20: v = 29'd81;
      21: v = 29'd41;
      22: v = 29'd20;
      23: v = 29'd10;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sin24b_cordic_stage.sv
// One rotation-mode CORDIC micro-rotation with registered x/y/z/valid outputs.
module sin24b_cordic_stage
  import sin24b_pkg::*;
#(
  parameter int unsigned SHIFT    = 0,
  parameter dp_t         ATAN_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  dp_t  i_x,
  input  dp_t  i_y,
  input  dp_t  i_z,
  output logic o_valid,
  output dp_t  o_x,
  output dp_t  o_y,
  output dp_t  o_z
);

  dp_t  w_xs;
  dp_t  w_ys;
  logic w_rot_pos;
  logic r_valid;
  dp_t  r_x;
  dp_t  r_y;
  dp_t  r_z;

  assign w_xs      = i_x >>> SHIFT;
  assign w_ys      = i_y >>> SHIFT;
  assign w_rot_pos = ~i_z[DP_W-1];

  // Rotate toward the residual angle; z steps by the quarter-turn arctangent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      r_valid <= i_valid;
      if (w_rot_pos) begin
        r_x <= i_x - w_ys;
        r_y <= i_y + w_xs;
        r_z <= i_z - ATAN_VAL;
      end else begin
        r_x <= i_x + w_ys;
        r_y <= i_y - w_xs;
        r_z <= i_z + ATAN_VAL;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;

endmodule

// File: rtl/sin24b_core.sv
// Pipelined CORDIC sine: 24-bit quarter-turn angle in, Q1.24 sine magnitude out.
// Latency is ITER+2 cycles (input reg, ITER stages, round reg, output reg).
// Build option SIN24B_SATURATE_EN clamps the result to at most 1.0 (2^24).
module sin24b_core
  import sin24b_pkg::*;
#(
  parameter int unsigned ITER = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in0,
  output logic             out_valid,
  output logic [OUT_W-1:0] out0
);

  logic                    r_v0;
  dp_t                     r_x0;
  dp_t                     r_y0;
  dp_t                     r_z0;
  logic                    w_v [0:ITER];
  dp_t                     w_x [0:ITER];
  dp_t                     w_y [0:ITER];
  dp_t                     w_z [0:ITER];
  dp_t                     w_y_rnd;
  logic                    r_v_rnd;
  logic signed [OUT_W:0]   r_sum;
  logic [OUT_W-1:0]        w_out_nxt;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out0;

`ifdef SIN24B_SATURATE_EN
  localparam logic [OUT_W-1:0] ONE_U = OUT_W'(1 << (OUT_W - 1));
`endif

  // Input register: start vector (K, 0) and the angle scaled into the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_x0 <= '0;
      r_y0 <= '0;
      r_z0 <= '0;
    end else begin
      r_v0 <= in_valid;
      r_x0 <= K_INIT;
      r_y0 <= '0;
      r_z0 <= DP_W'({2'b00, in0, {GUARD{1'b0}}});
    end
  end

  assign w_v[0] = r_v0;
  assign w_x[0] = r_x0;
  assign w_y[0] = r_y0;
  assign w_z[0] = r_z0;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    sin24b_cordic_stage #(
      .SHIFT    (i),
      .ATAN_VAL (atan_lut(i))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_v[i]),
      .i_x     (w_x[i]),
      .i_y     (w_y[i]),
      .i_z     (w_z[i]),
      .o_valid (w_v[i+1]),
      .o_x     (w_x[i+1]),
      .o_y     (w_y[i+1]),
      .o_z     (w_z[i+1])
    );
  end

  assign w_y_rnd = w_y[ITER] + RND_HALF;

  // Round stage: drop the guard bits with round-half-up, keep the sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_rnd <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_v_rnd <= w_v[ITER];
      r_sum   <= (OUT_W + 1)'(w_y_rnd >>> GUARD);
    end
  end

  // Clamp: negative results read as zero, optionally cap overshoot at 1.0.
  always_comb begin
    w_out_nxt = r_sum[OUT_W-1:0];
    if (r_sum[OUT_W]) begin
      w_out_nxt = '0;
    end
`ifdef SIN24B_SATURATE_EN
    else if (r_sum[OUT_W-1:0] > ONE_U) begin
      w_out_nxt = ONE_U;
    end
`endif
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out0      <= '0;
    end else begin
      r_out_valid <= r_v_rnd;
      r_out0      <= w_out_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out0      = r_out0;

endmodule

// File: tb/tb_sin24b_core.sv
// Scoreboard bench for sin24b_core: directed angles, random stream, mid-stream reset.
module tb_sin24b_core;

  localparam int unsigned LAT = 26;
  localparam int          TOL = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in0;
  logic        out_valid;
  logic [24:0] out0;

  typedef struct {
    logic [23:0] ang;
    int          expv;
    int unsigned t;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned total;
  int unsigned bad;

  sin24b_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .out_valid (out_valid),
    .out0      (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int model(input logic [23:0] a);
    real r;
    r = $sin(real'(a) / 16777216.0 * 1.5707963267948966) * 16777216.0;
    return $rtoi(r + 0.5);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  // Advance one edge, then compare any result the DUT presents against the scoreboard.
  task automatic tick();
    exp_t e;
    int   d;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_valid obs=1 exp=0 cyc=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        d = int'(out0) - e.expv;
        if (d < 0) d = -d;
        total++;
        assert (d <= TOL) else begin
          bad++;
          $error("FAIL value in0=%h obs=%0d exp=%0d", e.ang, out0, e.expv);
        end
        total++;
        assert (cyc === e.t + LAT) else begin
          bad++;
          $error("FAIL latency in0=%h obs=%0d exp=%0d", e.ang, cyc - (e.t - LAT) - LAT, LAT);
        end
`ifdef SIN24B_SATURATE_EN
        total++;
        assert (out0 <= 25'h1000000) else begin
          bad++;
          $error("FAIL saturate in0=%h obs=%0d exp<=16777216", e.ang, out0);
        end
`endif
      end
    end
  endtask

  // Present one input for the next edge; valid samples are queued with their expected result.
  task automatic drive(input logic v, input logic [23:0] a, input int expv);
    exp_t e;
    in_valid = v;
    in0      = a;
    if (v) begin
      e.ang  = a;
      e.expv = expv;
      e.t    = cyc + 1;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      drive(1'b0, 24'($urandom()), 0);
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [23:0] a;
    logic        v;
    cyc      = 0;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in0      = '0;
    repeat (3) tick();
    check_eq("reset_out0", int'(out0), 0);
    check_eq("reset_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();

    // Directed angles, back to back.
    drive(1'b1, 24'h000000, 0);
    drive(1'b1, 24'h800000, 11863283);
    drive(1'b1, 24'h400000, 6420362);
    drive(1'b1, 24'hFFFFFF, 16777216);
    drive(1'b1, 24'h000001, model(24'h000001));
    drive(1'b1, 24'hC00000, model(24'hC00000));
    drain();

    // Random stream with occasional gaps.
    for (int i = 0; i < 2000; i++) begin
      a = 24'($urandom());
      v = ($urandom_range(0, 7) != 0);
      drive(v, a, model(a));
    end
    drain();

    // Reset in the middle of a stream discards everything in flight.
    for (int i = 0; i < 40; i++) begin
      a = 24'($urandom());
      drive(1'b1, a, model(a));
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("midrst_out0", int'(out0), 0);
    check_eq("midrst_valid", int'(out_valid), 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 24'($urandom()), 0);
    end
    drive(1'b1, 24'h800000, 11863283);
    drive(1'b1, 24'h2AAAAA, model(24'h2AAAAA));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
